st_rs_queue: RTL
================

# st_rs_queue

Multi-entry store reservation queue for the store path of the issue stage, parametrised in depth. It holds up to DEPTH stores in program order and wakes their operands from the CDB. It sends the oldest operand-ready store to the AGU, captures the computed address, and records ROB commit permission per entry. It then releases stores strictly in order from the head to the memory stage, so several stores can be in flight instead of one.

## Interface
- DEPTH, 4: number of queue entries; power of two, at least 2.
- PIPE_WIDTH, uarch_pkg value: number of CDB ports and commit ports.
- TAG_WIDTH, uarch_pkg value: width of ROB tag.
- clk  in  1  clock; only clock of the block.
- rst  in  1  reset; synchronous and active-high.
- flush  in  1  pipeline flush (see Configuration).
- cache_stall  in  1  blocks memory-side dequeue.
- rs_entry  in  instruction_t  store from dispatch.
- rs_we  in  1  enqueue strobe; legal only when rs_write_rdy=1.
- rs_write_rdy  out  1  queue not full; computed from registered count.
- cdb_ports  in  writeback_packet_t[PIPE_WIDTH]  operand wakeup.
- agu_read_rdy  out  1  agu_execute_pkt valid.
- agu_execute_pkt  out  instruction_t  oldest WAIT_REG entry with both operands ready.
- agu_re  in  1  AGU accepts agu_execute_pkt this cycle.
- agu_port  in  writeback_packet_t  AGU result; dest_tag identifies the entry.
- commit_store_ids  in  TAG_WIDTH[PIPE_WIDTH]  ROB store commits.
- commit_store_vals  in  PIPE_WIDTH  valid bits for commit_store_ids.
- rs_read_rdy  out  1  head store is ready for memory.
- execute_pkt  out  instruction_t  head entry.
- alu_re  in  1  memory stage accepts execute_pkt.
- count  out  $clog2(DEPTH)+1  number of occupied entries.

## Operation
- The queue is a circular buffer with head and tail pointers of $clog2(DEPTH) bits that wrap modulo DEPTH, plus the count register.
- Per-entry state is one of: INVALID, WAIT_REG, WAIT_AGU, ADDR_DONE. Each entry also has a perm bit.
- Enqueue (rs_we): write rs_entry at the tail. In the same cycle, rs_entry is forwarded any CDB port whose dest_tag matches an unready source. The entry state becomes WAIT_REG and perm becomes 0. Tail increments.
- Wakeup: every valid entry compares each unready source tag against every valid CDB port. On a match it captures the data and sets the ready flag.
- AGU select: the oldest WAIT_REG entry (closest to head) with both sources ready drives agu_execute_pkt, and agu_read_rdy=1. When agu_read_rdy=1 and agu_re=1, the entry moves to WAIT_AGU.
- AGU writeback: when agu_port.is_valid=1, the WAIT_AGU entry whose dest_tag matches agu_port.dest_tag takes agu_port.result into src_0_a.data. That entry sets agu_comp=1 and moves to ADDR_DONE. A writeback with no matching entry is ignored.
- Commit: for every k with commit_store_vals[k]=1, the valid entry whose dest_tag equals commit_store_ids[k] sets perm=1. All PIPE_WIDTH ports apply in the same cycle.
- Dequeue: rs_read_rdy = head state is ADDR_DONE, perm=1 and cache_stall=0. When rs_read_rdy=1 and alu_re=1, the head entry becomes INVALID and head increments.
- count = count + enqueue − dequeue.

## Timing
- Reset: all entries INVALID with perm=0; head=tail=0; count=0. Outputs after reset: rs_write_rdy=1, agu_read_rdy=0, rs_read_rdy=0, agu_execute_pkt='0, execute_pkt='0.
- Enqueue to agu_read_rdy: 1 cycle minimum, when operands are ready at dispatch or forwarded by the CDB in the same cycle.
- AGU writeback to rs_read_rdy: 1 cycle if perm=1 already; otherwise 1 cycle after the commit is seen.
- Full: rs_write_rdy=0 when count=DEPTH, even if a dequeue happens in the same cycle.
- Empty: simultaneous enqueue and dequeue are impossible because the head is INVALID.
- Simultaneous CDB wakeup, AGU writeback and commit on different entries all take effect in the same cycle.
- Priority: rst > flush > normal operation.
- Reset mid-operation discards all entries.

## Configuration
- ST_RS_KEEP_COMMITTED_EN defined: flush keeps the contiguous prefix of perm=1 entries starting at head. Tail is set to head plus the length of that prefix, and count is set to the prefix length. Those entries continue to drain normally.
- ST_RS_KEEP_COMMITTED_EN undefined: flush clears every entry and resets head, tail and count to 0, the same as reset.

## Test plan
- Reset, then enqueue 1 store with ready operands: agu_read_rdy=1 the next cycle. Pulse agu_re. Return agu_port result 0x1000. Commit its tag. Then rs_read_rdy=1 with execute_pkt.src_0_a.data=0x1000. Pulse alu_re: count returns to 0.
- Enqueue DEPTH=4 stores: rs_write_rdy=0 and count=4. A 5th rs_we is not issued. Dequeue one: rs_write_rdy=1 the next cycle. Continue enqueueing until the tail wraps to index 0.
- Store A waits on a source while younger store B is ready: B issues to the AGU first. Commit B before A: rs_read_rdy stays 0 until A reaches ADDR_DONE with perm=1. Then A dequeues before B.
- Two commits on ports 0 and 1 in the same cycle for the head and head+1: both perm bits are set, and the two stores dequeue on consecutive cycles. Holding cache_stall=1 keeps rs_read_rdy=0.
- 3 entries, head committed, flush: with the macro, count=1 and the committed store still dequeues. Without it, count=0 and rs_read_rdy=0.
- A CDB tag match in the same cycle as rs_we: the entry is captured with the operand ready, and agu_read_rdy=1 the next cycle.

Source files
------------

// File: rtl/st_rs_queue.sv
// st_rs_queue: in-order store reservation queue with CDB wakeup, AGU issue and ROB commit; define ST_RS_KEEP_COMMITTED_EN to keep the committed head prefix on flush
package uarch_pkg;
  localparam int PIPE_WIDTH = 2;
  localparam int TAG_WIDTH = 4;
  localparam int XLEN = 32;
  typedef struct packed {
    logic [TAG_WIDTH-1:0] tag;
    logic                 rdy;
    logic [XLEN-1:0]      data;
  } src_t;
  typedef struct packed {
    logic [TAG_WIDTH-1:0] dest_tag;
    src_t                 src_0_a;
    src_t                 src_0_b;
    logic [XLEN-1:0]      imm;
    logic                 agu_comp;
  } instruction_t;
  typedef struct packed {
    logic                 is_valid;
    logic [TAG_WIDTH-1:0] dest_tag;
    logic [XLEN-1:0]      result;
  } writeback_packet_t;
endpackage

module st_rs_queue
  import uarch_pkg::instruction_t, uarch_pkg::writeback_packet_t;
#(
  parameter int DEPTH = 4,
  parameter int PIPE_WIDTH = uarch_pkg::PIPE_WIDTH,
  parameter int TAG_WIDTH = uarch_pkg::TAG_WIDTH
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 flush,
  input  logic                                 cache_stall,
  input  instruction_t                         rs_entry,
  input  logic                                 rs_we,
  output logic                                 rs_write_rdy,
  input  writeback_packet_t [PIPE_WIDTH-1:0]   cdb_ports,
  output logic                                 agu_read_rdy,
  output instruction_t                         agu_execute_pkt,
  input  logic                                 agu_re,
  input  writeback_packet_t                    agu_port,
  input  logic [PIPE_WIDTH-1:0][TAG_WIDTH-1:0] commit_store_ids,
  input  logic [PIPE_WIDTH-1:0]                commit_store_vals,
  output logic                                 rs_read_rdy,
  output instruction_t                         execute_pkt,
  input  logic                                 alu_re,
  output logic [$clog2(DEPTH):0]               count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  typedef enum logic [1:0] {INVALID, WAIT_REG, WAIT_AGU, ADDR_DONE} state_t;
  instruction_t ent_q [DEPTH];
  instruction_t ent_d [DEPTH];
  state_t       st_q  [DEPTH];
  state_t       st_d  [DEPTH];
  logic [DEPTH-1:0] perm_q, perm_d;
  logic [PW-1:0] head_q, head_d, tail_q, tail_d, agu_sel;
  logic [CW-1:0] count_q, count_d;
  logic enq, deq;
  function automatic instruction_t wake(input instruction_t e, input writeback_packet_t [PIPE_WIDTH-1:0] c);
    instruction_t r;
    r = e;
    for (int k = 0; k < PIPE_WIDTH; k++) begin
      if (c[k].is_valid && !r.src_0_a.rdy && r.src_0_a.tag == c[k].dest_tag) begin
        r.src_0_a.data = c[k].result;
        r.src_0_a.rdy  = 1'b1;
      end
      if (c[k].is_valid && !r.src_0_b.rdy && r.src_0_b.tag == c[k].dest_tag) begin
        r.src_0_b.data = c[k].result;
        r.src_0_b.rdy  = 1'b1;
      end
    end
    return r;
  endfunction
  assign rs_write_rdy    = count_q != CW'(DEPTH);
  assign rs_read_rdy     = st_q[head_q] == ADDR_DONE && perm_q[head_q] && !cache_stall;
  assign deq             = rs_read_rdy && alu_re;
  assign enq             = rs_we && rs_write_rdy;
  assign count           = count_q;
  assign execute_pkt     = st_q[head_q] != INVALID ? ent_q[head_q] : '0;
  assign agu_execute_pkt = agu_read_rdy ? ent_q[agu_sel] : '0;
  always_comb begin
    agu_read_rdy = 1'b0;
    agu_sel      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!agu_read_rdy && st_q[head_q + PW'(i)] == WAIT_REG && ent_q[head_q + PW'(i)].src_0_a.rdy && ent_q[head_q + PW'(i)].src_0_b.rdy) begin
        agu_read_rdy = 1'b1;
        agu_sel      = head_q + PW'(i);
      end
    end
  end
`ifdef ST_RS_KEEP_COMMITTED_EN
  logic [CW-1:0] keep;
  always_comb begin
    keep = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (keep == CW'(i) && st_q[head_q + PW'(i)] != INVALID && perm_q[head_q + PW'(i)]) keep = CW'(i + 1);
    end
  end
`endif
  always_comb begin
    ent_d   = ent_q;
    st_d    = st_q;
    perm_d  = perm_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (st_q[i] != INVALID) ent_d[i] = wake(ent_q[i], cdb_ports);
      if (agu_port.is_valid && st_q[i] == WAIT_AGU && ent_q[i].dest_tag == agu_port.dest_tag) begin
        ent_d[i].src_0_a.data = agu_port.result;
        ent_d[i].agu_comp     = 1'b1;
        st_d[i]               = ADDR_DONE;
      end
      for (int k = 0; k < PIPE_WIDTH; k++) begin
        if (commit_store_vals[k] && st_q[i] != INVALID && ent_q[i].dest_tag == commit_store_ids[k]) perm_d[i] = 1'b1;
      end
    end
    if (agu_read_rdy && agu_re) st_d[agu_sel] = WAIT_AGU;
    if (flush) begin
`ifdef ST_RS_KEEP_COMMITTED_EN
      for (int j = 0; j < DEPTH; j++) begin
        if (CW'(j) >= keep) begin
          st_d[head_q + PW'(j)]   = INVALID;
          perm_d[head_q + PW'(j)] = 1'b0;
        end
      end
      tail_d  = head_q + keep[PW-1:0];
      count_d = keep;
`else
      st_d    = '{default: INVALID};
      perm_d  = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
`endif
    end else begin
      if (deq) begin
        st_d[head_q]   = INVALID;
        perm_d[head_q] = 1'b0;
        head_d         = head_q + PW'(1);
      end
      if (enq) begin
        ent_d[tail_q]  = wake(rs_entry, cdb_ports);
        st_d[tail_q]   = WAIT_REG;
        perm_d[tail_q] = 1'b0;
        tail_d         = tail_q + PW'(1);
      end
      count_d = count_q + CW'(enq) - CW'(deq);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ent_q   <= '{default: '0};
      st_q    <= '{default: INVALID};
      perm_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      ent_q   <= ent_d;
      st_q    <= st_d;
      perm_q  <= perm_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end
endmodule
